// File: rtl/serial_rx_port.sv
// Memory-mapped 8N1 serial receive port: 2-flop synchroniser, RX FSM, byte FIFO
// and a DATA/STATUS register pair for the CPU bus decode.
module serial_rx_port #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       sel,
    input  logic       addr,
    input  logic       rd_en,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]      LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]      HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_sync1, r_sync2;
    logic                w_rxs;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [2:0]          r_idx, w_idx_nxt;
    logic [7:0]          r_shift, w_shift_nxt;
    logic                w_push_req, w_ferr_set;

    logic [7:0]          r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wptr, r_rptr;
    logic [FIFO_AW:0]    r_count, w_count_nxt;
    logic                r_ovr, r_ferr;
    logic                w_full, w_nonempty;
    logic                w_rd_hit, w_wr_hit, w_pop, w_push, w_ovr_set;
    logic [7:0]          w_rdata;

    // Synchroniser presets to the idle level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push_req  = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
                    else               w_idx_nxt   = r_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_push_req  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rxs) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_full     = (r_count == CNT_FULL);
    assign w_nonempty = (r_count != '0);
    assign w_rd_hit   = sel & rd_en;
    assign w_wr_hit   = sel & wr_en & ~rd_en;
    assign w_pop      = w_rd_hit & ~addr & w_nonempty;
    // A pop in the same clk frees the slot, so a push into a full FIFO still lands.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovr_set  = w_push_req & w_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (FIFO_AW + 1)'(1);
            2'b01:   w_count_nxt = r_count - (FIFO_AW + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_rdata = 8'h00;
        if (addr)            w_rdata = {4'b0000, w_full, r_ferr, r_ovr, w_nonempty};
        else if (w_nonempty) w_rdata = r_mem[r_rptr];
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
            data_out <= '0;
            irq      <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
            r_count <= w_count_nxt;
            irq     <= (w_count_nxt != '0);
            if (w_rd_hit) data_out <= w_rdata;
            if (w_ovr_set)                          r_ovr <= 1'b1;
            else if (w_wr_hit & addr & data_in[1])  r_ovr <= 1'b0;
            if (w_ferr_set)                         r_ferr <= 1'b1;
            else if (w_wr_hit & addr & data_in[2])  r_ferr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_rx_port.sv
// Directed bench for serial_rx_port: register-access vector table plus
// hand-timed serial frames for glitch, overrun, framing error and reset cases.
module tb_serial_rx_port;

    localparam int CPB = 8;
    localparam int AW  = 2;

    logic       clk = 1'b0;
    logic       reset_n, rxd, sel, addr, rd_en, wr_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rd;
        logic       wr;
        logic       a;
        logic [7:0] din;
        logic       chk;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    vec_t tbl [11];

    serial_rx_port #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rxd      (rxd),
        .sel      (sel),
        .addr     (addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        tick(CPB);
    endtask

    task automatic send_head(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        send_bit(1'b1);
        tick(4);
    endtask

    task automatic bus(input logic rd, input logic wr, input logic a, input logic [7:0] d);
        sel = 1'b1; rd_en = rd; wr_en = wr; addr = a; data_in = d;
        tick(1);
        sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0; data_in = 8'h00;
    endtask

    task automatic rd_chk(input logic a, input logic [7:0] exp, input string nm);
        bus(1'b1, 1'b0, a, 8'h00);
        check(nm, data_out, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h0B, "t3_status_full_ovr"};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, "t3_data_write_ignored"};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, "t3_read0"};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, "t3_read1"};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, "t3_read2"};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, "t3_read3"};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, "t3_read_empty"};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 8'h02, "t3_rdwr_read_wins"};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02, "t3_ovr_still_set"};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00, "t3_clear_ovr"};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "t3_status_clear"};

        reset_n = 1'b0; rxd = 1'b1; sel = 1'b0; addr = 1'b0;
        rd_en = 1'b0; wr_en = 1'b0; data_in = 8'h00;
        tick(3);
        check("rst_data_out", data_out, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        reset_n = 1'b1;
        tick(3);
        rd_chk(1'b1, 8'h00, "rst_status");

        // 1: single byte
        send_byte(8'hA5);
        check("t1_irq_high", {7'b0, irq}, 8'h01);
        rd_chk(1'b1, 8'h01, "t1_status");
        rd_chk(1'b0, 8'hA5, "t1_data");
        tick(1);
        check("t1_irq_low", {7'b0, irq}, 8'h00);
        rd_chk(1'b1, 8'h00, "t1_status_empty");

        // 2: short low glitch is ignored, receiver still usable
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        rd_chk(1'b1, 8'h00, "t2_no_push_no_ferr");
        send_byte(8'hC3);
        rd_chk(1'b0, 8'hC3, "t2_after_glitch_byte");

        // 3: overrun, then register access table
        for (int b = 1; b <= 5; b++) send_byte(8'(b));
        for (int unsigned i = 0; i < 11; i++) begin
            bus(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].din);
            if (tbl[i].chk) check(tbl[i].nm, data_out, tbl[i].exp);
        end
        check("t3_irq_low", {7'b0, irq}, 8'h00);

        // 4: framing error followed by a held-low line
        send_head(8'h3C);
        rxd = 1'b0;
        tick(CPB + 5);
        rd_chk(1'b1, 8'h04, "t4_ferr_set");
        bus(1'b0, 1'b1, 1'b1, 8'h04);
        rd_chk(1'b1, 8'h00, "t4_ferr_cleared");
        tick(30);
        rxd = 1'b1;
        tick(20);
        rd_chk(1'b1, 8'h00, "t4_single_ferr_empty");

        // 5: pop on the same clk as a push into a full FIFO
        for (int b = 1; b <= 4; b++) send_byte(8'(b * 8'h11));
        rd_chk(1'b1, 8'h09, "t5_full");
        send_head(8'h77);
        rxd = 1'b1;
        tick(6);
        rd_chk(1'b0, 8'h11, "t5_pop_at_push");
        tick(4);
        rd_chk(1'b1, 8'h09, "t5_full_no_ovr");
        rd_chk(1'b0, 8'h22, "t5_read1");
        rd_chk(1'b0, 8'h33, "t5_read2");
        rd_chk(1'b0, 8'h44, "t5_read3");
        rd_chk(1'b0, 8'h77, "t5_read_last");
        rd_chk(1'b1, 8'h00, "t5_empty");

        // 6: reset in the middle of a frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd = 1'b0;
        tick(4);
        reset_n = 1'b0;
        rxd = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        rd_chk(1'b1, 8'h00, "t6_after_reset");
        send_byte(8'h5A);
        rd_chk(1'b1, 8'h01, "t6_one_byte");
        rd_chk(1'b0, 8'h5A, "t6_data");
        rd_chk(1'b1, 8'h00, "t6_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
